rr_mux4: RTL and testbench

RR_MUX4 -- requirements
Module: rr_mux4

---
 rtl/rr_mux4_if.sv | 31 +++
 rtl/rr_mux4.sv | 96 +++++++++
 tb/tb_rr_mux4.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rr_mux4_if.sv
// ============================================================================
// rr_mux4_if : four valid/ready input lanes and one valid/ready output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface rr_mux4_if #(
   parameter int WIDTH = 8
);
   logic [3:0]         in_valid;
   logic [4*WIDTH-1:0] in_data;
   logic [3:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [1:0]         out_sel;
   logic               out_ready;

   // master: the merging block itself
   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   // slave: the lanes feeding it and the consumer draining it
   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

`default_nettype wire

// File: rtl/rr_mux4.sv
// ============================================================================
// rr_mux4 : round-robin 4:1 valid/ready merge into a registered output beat
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_mux4 #(
   parameter int WIDTH = 8
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   rr_mux4_if.master   bus
);
   logic [1:0]       ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [1:0]       out_sel_q, out_sel_d;
   logic             run_q;

   logic             w_load_en;
   logic             w_found;
   logic             w_accept;
   logic [1:0]       w_idx;
   logic [1:0]       w_gidx;
   logic [3:0]       w_grant;
   logic [WIDTH-1:0] w_gdata;

   assign w_load_en = !out_valid_q | bus.out_ready;

   // First valid lane at or above ptr, wrapping modulo 4.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = 2'd0;
      w_grant = 4'b0000;
      w_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_idx = ptr_q + 2'(k);
         if (!w_found && bus.in_valid[w_idx]) begin
            w_found        = 1'b1;
            w_gidx         = w_idx;
            w_grant[w_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      w_gdata = '0;
      for (int i = 0; i < 4; i++) begin
         if (w_gidx == 2'(i)) begin
            w_gdata = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // run_q keeps the release edge itself from accepting a beat.
   assign w_accept     = w_found & w_load_en & run_q;
   assign bus.in_ready = w_grant & {4{w_load_en & run_q}};

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (w_accept) begin
         out_valid_d = 1'b1;
         out_data_d  = w_gdata;
         out_sel_d   = w_gidx;
         ptr_d       = w_gidx + 2'd1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= 2'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 2'd0;
         run_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         run_q       <= 1'b1;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux4.sv
// ============================================================================
// tb_rr_mux4 : vector table plus scoreboard bench for rr_mux4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux4;
   localparam int WIDTH = 8;
   localparam int NVEC  = 25;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic        r;
      logic [3:0]  er;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rr_mux4_if #(.WIDTH(WIDTH)) bus ();

   rr_mux4 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state of the output register, and beats awaiting emission.
   logic [1:0]  m_ptr;
   logic        m_valid;
   logic [7:0]  m_data;
   logic [1:0]  m_sel;
   logic        m_run;
   logic [9:0]  sb_q [$];
   vec_t        tbl [NVEC];

   function automatic logic [3:0] gsearch(input logic [3:0] v, input logic [1:0] p);
      logic [1:0] idx;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (v[idx]) return 4'b0001 << idx;
      end
      return 4'b0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic r,
                        input logic [3:0] er, input bit has_er);
      logic [3:0] g;
      logic [9:0] item;
      logic [1:0] gi;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = r;
      #1;
      g = (m_run && (!m_valid || r)) ? gsearch(v, m_ptr) : 4'b0000;
      if (has_er && (g !== er)) $display("bench table disagrees with model at %0t", $time);
      check("in_ready", {28'd0, bus.in_ready}, {28'd0, has_er ? er : g});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      if (m_valid) begin
         check("out_data", {24'd0, bus.out_data}, {24'd0, m_data});
         check("out_sel", {30'd0, bus.out_sel}, {30'd0, m_sel});
      end
      if (bus.out_valid && r) begin
         if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
         end else begin
            item = sb_q.pop_front();
            check("sb_beat", {22'd0, bus.out_sel, bus.out_data}, {22'd0, item});
         end
      end
      if (g != 4'b0000) begin
         gi = 2'd0;
         for (int i = 0; i < 4; i++) if (g[i]) gi = 2'(i);
         m_data  = d[gi*8 +: 8];
         m_sel   = gi;
         m_valid = 1'b1;
         m_ptr   = gi + 2'd1;
         sb_q.push_back({gi, m_data});
      end else if (r) begin
         m_valid = 1'b0;
      end
      m_run = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_ptr   = 2'd0;
      m_valid = 1'b0;
      m_data  = 8'd0;
      m_sel   = 2'd0;
      m_run   = 1'b0;
      sb_q.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.in_valid  = 4'b0000;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();

      for (int i = 0; i < 8; i++)
         tbl[i] = '{4'b1111, 32'h13121110, 1'b1, 4'b0001 << (i % 4)};
      tbl[8]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100};
      tbl[9]  = '{4'b1001, 32'hD30000D0, 1'b1, 4'b1000};
      tbl[10] = '{4'b1001, 32'hD30000D0, 1'b1, 4'b0001};
      tbl[11] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};
      tbl[12] = '{4'b1111, 32'h33223C00, 1'b1, 4'b0010};
      tbl[13] = '{4'b1111, 32'h33223C00, 1'b0, 4'b0000};
      tbl[14] = '{4'b1111, 32'h33223C00, 1'b0, 4'b0000};
      tbl[15] = '{4'b1111, 32'h33223C00, 1'b0, 4'b0000};
      tbl[16] = '{4'b1111, 32'h33223C00, 1'b1, 4'b0100};
      tbl[17] = '{4'b1111, 32'h33223C00, 1'b0, 4'b0000};
      tbl[18] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};
      tbl[19] = '{4'b0000, 32'h00000000, 1'b0, 4'b0000};
      tbl[20] = '{4'b1000, 32'h77000000, 1'b1, 4'b1000};
      tbl[21] = '{4'b1000, 32'h77000000, 1'b0, 4'b0000};
      tbl[22] = '{4'b0100, 32'h00660000, 1'b0, 4'b0000};
      tbl[23] = '{4'b0000, 32'h00000000, 1'b1, 4'b0000};
      tbl[24] = '{4'b0011, 32'h00005544, 1'b1, 4'b0001};

      @(negedge clk);
      #1;
      check("rst_in_ready", {28'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
      check("rst_out_sel", {30'd0, bus.out_sel}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      m_run = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NVEC; i++)
         cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].er, 1'b1);

      // Mid-stream asynchronous reset: held beat from lane 0 is discarded.
      check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("arst_out_data", {24'd0, bus.out_data}, 32'd0);
      check("arst_out_sel", {30'd0, bus.out_sel}, 32'd0);
      check("arst_in_ready", {28'd0, bus.in_ready}, 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #3 rst_n = 1'b1;
      cycle(4'b1010, 32'h00BB00AA, 1'b1, 4'b0000, 1'b1);
      cycle(4'b1010, 32'hDD00CC00, 1'b1, 4'b0010, 1'b1);
      cycle(4'b1010, 32'hDD00CC00, 1'b1, 4'b1000, 1'b1);

      for (int i = 0; i < 100; i++)
         cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0), 4'b0000, 1'b0);

      for (int i = 0; i < 10 && (m_valid || sb_q.size() != 0); i++)
         cycle(4'b0000, 32'd0, 1'b1, 4'b0000, 1'b0);
      check("sb_drained", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
